// File: rtl/pw_imm_pkg.sv
// Shared immediate-path definitions: field widths, signed range limits,
// skid-buffer state encoding and the buffered entry layout.
package pw_imm_pkg;

  localparam int unsigned IMM_IN_W  = 8;
  localparam int unsigned IMM_OUT_W = 6;
  localparam int          IMM_MIN   = -32;
  localparam int          IMM_MAX   = 31;

  // Saturation endpoints of the narrow field (6'b100000 / 6'b011111)
  localparam logic [IMM_OUT_W-1:0] IMM_SAT_LO = IMM_OUT_W'(IMM_MIN);
  localparam logic [IMM_OUT_W-1:0] IMM_SAT_HI = IMM_OUT_W'(IMM_MAX);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic                 ovf;
    logic [IMM_OUT_W-1:0] data;
  } imm_entry_t;

  // A value fits when every bit from the narrow sign bit upward agrees.
  function automatic logic imm_fits(input logic [IMM_IN_W-1:0] v);
    logic [IMM_IN_W-IMM_OUT_W:0] top;
    top = v[IMM_IN_W-1:IMM_OUT_W-1];
    return (&top) | ~(|top);
  endfunction

endpackage

// File: rtl/narrow_core.sv
// Combinational 8->6 bit signed narrowing with overflow detection.
// Define SIGN_NARROW_SAT_EN to clamp overflowing values instead of truncating.
module narrow_core
  import pw_imm_pkg::*;
(
  input  logic [IMM_IN_W-1:0] value,
  output imm_entry_t          entry_c
);

  logic fit_c;

  assign fit_c = imm_fits(value);

  always_comb begin
    entry_c.ovf  = ~fit_c;
    entry_c.data = value[IMM_OUT_W-1:0];
`ifdef SIGN_NARROW_SAT_EN
    // Clamp toward the sign of the wide value
    if (!fit_c) begin
      entry_c.data = value[IMM_IN_W-1] ? IMM_SAT_LO : IMM_SAT_HI;
    end
`endif
  end

endmodule

// File: rtl/sign_narrow.sv
// Narrows signed 8-bit values to 6-bit immediates behind a 2-entry skid buffer,
// with sticky overflow flag and saturating overflow counter. Optional macro: SIGN_NARROW_SAT_EN.
module sign_narrow
  import pw_imm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IMM_IN_W-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IMM_OUT_W-1:0] out_data,
  output logic                 out_ovf,
  output logic                 ovf_flag,
  output logic [CNT_W-1:0]     ovf_count,
  input  logic                 clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  buf_state_e state;
  imm_entry_t new_c;
  imm_entry_t head;
  imm_entry_t tail;
  logic       accept_c;
  logic       pop_c;

  assign accept_c = in_valid & in_ready;
  assign pop_c    = out_valid & out_ready;

  narrow_core u_core (
    .value   (in_data),
    .entry_c (new_c)
  );

  // Skid buffer: head drives the outputs, tail holds the second entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      head      <= '0;
      tail      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept_c) begin
            head      <= new_c;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept_c && !pop_c) begin
            tail     <= new_c;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (accept_c && pop_c) begin
            head <= new_c;
          end else if (pop_c) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (pop_c) begin
            head     <= tail;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = head.data;
  assign out_ovf  = head.ovf;

  // Overflow statistics; clr takes priority over a same-cycle overflow
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ovf_flag  <= 1'b0;
      ovf_count <= '0;
    end else if (accept_c && new_c.ovf) begin
      ovf_flag <= 1'b1;
      if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

endmodule
